// File: rtl/uart_rx_fifo.sv
// Parametrised UART receiver: 2-flop synchroniser, oversampled majority-vote bit
// recovery, optional parity, 1/2 stop bits, and a show-ahead FIFO on a valid/ready port.
module uart_rx_fifo #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD_RATE  = 115200,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rx,
  output logic [DATA_BITS-1:0]          m_data,
  output logic                          m_parity_err,
  output logic                          m_frame_err,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic                          overrun,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int DIV_RAW = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int SC_W    = $clog2(OVERSAMPLE);
  localparam int BC_W    = $clog2(DATA_BITS);
  localparam int AW      = $clog2(FIFO_DEPTH);
  localparam int CW      = AW + 1;
  localparam int W       = DATA_BITS + 2;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [SC_W-1:0]  SC_S0    = SC_W'(OVERSAMPLE / 2 - 1);
  localparam logic [SC_W-1:0]  SC_S1    = SC_W'(OVERSAMPLE / 2);
  localparam logic [SC_W-1:0]  SC_DEC   = SC_W'(OVERSAMPLE / 2 + 1);
  localparam logic [SC_W-1:0]  SC_LAST  = SC_W'(OVERSAMPLE - 1);
  localparam logic [BC_W-1:0]  BC_LAST  = BC_W'(DATA_BITS - 1);
  localparam logic             STOP_LAST = (STOP_BITS == 2);
  localparam logic             ODD       = (PARITY_ODD != 0);
  localparam logic [CW-1:0]    FULL_CNT  = CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  logic                 rx_meta_q, rx_s_q;
  logic [DIV_W-1:0]     div_cnt_q;
  logic                 tick;
  state_t               state_q;
  logic [SC_W-1:0]      sc_q;
  logic [BC_W-1:0]      bit_cnt_q;
  logic                 stop_cnt_q;
  logic                 s0_q, s1_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 perr_q, ferr_q;
  logic                 armed_q;
  logic                 start_det, vote, decide, bit_end, push;
  logic [W-1:0]         push_word;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  always_comb begin
    tick      = (div_cnt_q == DIV_LAST);
    start_det = (state_q == S_IDLE) && armed_q && !rx_s_q;
    vote      = (s0_q & s1_q) | (s0_q & rx_s_q) | (s1_q & rx_s_q);
    decide    = tick && (sc_q == SC_DEC);
    bit_end   = tick && (sc_q == SC_LAST);
    push      = (state_q == S_STOP) && decide && (stop_cnt_q == STOP_LAST);
    push_word = {shift_q, perr_q, ferr_q | !vote};
  end

  // Restarting on the start edge phase-aligns every sample to the received frame.
  always_ff @(posedge clk) begin
    if (rst || start_det) begin
      div_cnt_q <= '0;
    end else if (tick) begin
      div_cnt_q <= '0;
    end else begin
      div_cnt_q <= div_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      sc_q       <= '0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      s0_q       <= 1'b1;
      s1_q       <= 1'b1;
      shift_q    <= '0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      armed_q    <= 1'b0;
    end else begin
      if (tick && (sc_q == SC_S0)) s0_q <= rx_s_q;
      if (tick && (sc_q == SC_S1)) s1_q <= rx_s_q;
      if (tick) sc_q <= bit_end ? '0 : sc_q + 1'b1;

      case (state_q)
        S_IDLE: begin
          sc_q <= '0;
          // After a break the line must go high again before a new start edge counts.
          if (!armed_q) begin
            armed_q <= rx_s_q;
          end else if (!rx_s_q) begin
            state_q    <= S_START;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
          end
        end
        S_START: begin
          if (decide && vote) begin
            state_q <= S_IDLE;
          end else if (bit_end) begin
            state_q <= S_DATA;
          end
        end
        S_DATA: begin
          if (decide) shift_q <= {vote, shift_q[DATA_BITS-1:1]};
          if (bit_end) begin
            if (bit_cnt_q == BC_LAST) begin
              state_q <= (PARITY_EN != 0) ? S_PARITY : S_STOP;
            end else begin
              bit_cnt_q <= bit_cnt_q + 1'b1;
            end
          end
        end
        S_PARITY: begin
          if (decide) perr_q <= (^shift_q) ^ vote ^ ODD;
          if (bit_end) state_q <= S_STOP;
        end
        S_STOP: begin
          if (decide) begin
            if (!vote) ferr_q <= 1'b1;
            if (stop_cnt_q == STOP_LAST) begin
              state_q <= S_IDLE;
              armed_q <= 1'b0;
            end
          end
          if (bit_end) stop_cnt_q <= 1'b1;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  logic [W-1:0]  mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [CW-1:0] count_q, count_d;
  logic          overrun_q, pop, push_ok, full;

  // Valid/ready: a word transfers on any cycle with m_valid & m_ready; the head
  // entry is held unchanged on the outputs until that happens.
  always_comb begin
    full    = (count_q == FULL_CNT);
    m_valid = (count_q != '0);
    pop     = m_valid && m_ready;
    push_ok = push && (!full || pop);
    count_d = count_q;
    case ({push_ok, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_q] <= push_word;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q      <= '0;
      rd_q      <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      if (push_ok) wr_q <= wr_q + 1'b1;
      if (pop) rd_q <= rd_q + 1'b1;
      count_q   <= count_d;
      overrun_q <= push && full && !pop;
    end
  end

  always_comb begin
    {m_data, m_parity_err, m_frame_err} = m_valid ? mem_q[rd_q] : '0;
    overrun    = overrun_q;
    fifo_count = count_q;
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: three instances (8N1 depth 4, even parity, two stop bits)
// driven with serial frames; a scoreboard checks every word popped from each FIFO.
module tb_uart_rx_fifo;

  localparam int BIT_CLKS = 16;
  // rx pin to m_valid: two synchroniser flops and the idle-detect cycle precede bit timing.
  localparam int LAT_MAX  = 16 * 9 + 10 + 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [2:0] rx_v, rdy, mv, pe, fe, ovr;
  logic [7:0] md [3];
  logic [2:0] cnt0;
  logic [3:0] cnt1, cnt2;

  int checks = 0;
  int failures = 0;
  logic [9:0] exp_q0[$];
  logic [9:0] exp_q1[$];
  logic [9:0] exp_q2[$];

  typedef struct {
    int         u;
    logic [7:0] d;
    logic       par;
    logic [1:0] stp;
    logic       eperr;
    logic       eferr;
  } vec_t;
  vec_t vecs[11];

  logic [9:0] mon_e;
  bit         mon_have;
  int         lat, ovr_cnt;
  bit         sending;

  uart_rx_fifo #(.CLK_FREQ(1_600_000), .BAUD_RATE(100_000), .OVERSAMPLE(16), .DATA_BITS(8),
                 .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u_8n1 (
    .clk(clk), .rst(rst), .rx(rx_v[0]), .m_data(md[0]), .m_parity_err(pe[0]),
    .m_frame_err(fe[0]), .m_valid(mv[0]), .m_ready(rdy[0]), .overrun(ovr[0]),
    .fifo_count(cnt0));

  uart_rx_fifo #(.CLK_FREQ(1_600_000), .BAUD_RATE(100_000), .OVERSAMPLE(16), .DATA_BITS(8),
                 .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1), .FIFO_DEPTH(8)) u_par (
    .clk(clk), .rst(rst), .rx(rx_v[1]), .m_data(md[1]), .m_parity_err(pe[1]),
    .m_frame_err(fe[1]), .m_valid(mv[1]), .m_ready(rdy[1]), .overrun(ovr[1]),
    .fifo_count(cnt1));

  uart_rx_fifo #(.CLK_FREQ(1_600_000), .BAUD_RATE(100_000), .OVERSAMPLE(16), .DATA_BITS(8),
                 .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2), .FIFO_DEPTH(8)) u_2stop (
    .clk(clk), .rst(rst), .rx(rx_v[2]), .m_data(md[2]), .m_parity_err(pe[2]),
    .m_frame_err(fe[2]), .m_valid(mv[2]), .m_ready(rdy[2]), .overrun(ovr[2]),
    .fifo_count(cnt2));

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h", name, got, exp);
    end
  endtask

  task automatic push_exp(input int u, input logic [9:0] w);
    case (u)
      0:       exp_q0.push_back(w);
      1:       exp_q1.push_back(w);
      default: exp_q2.push_back(w);
    endcase
  endtask

  function automatic int qsize(input int u);
    case (u)
      0:       return exp_q0.size();
      1:       return exp_q1.size();
      default: return exp_q2.size();
    endcase
  endfunction

  task automatic drive_bit(input int u, input logic b);
    rx_v[u] = b;
    repeat (BIT_CLKS) @(negedge clk);
  endtask

  task automatic idle_bits(input int u, input int n);
    for (int i = 0; i < n; i++) drive_bit(u, 1'b1);
  endtask

  // Frame shape follows the instance: unit 1 carries a parity bit, unit 2 two stop bits.
  task automatic send_frame(input int u, input logic [7:0] d, input logic par,
                            input logic [1:0] stp);
    drive_bit(u, 1'b0);
    for (int i = 0; i < 8; i++) drive_bit(u, d[i]);
    if (u == 1) drive_bit(u, par);
    drive_bit(u, stp[0]);
    if (u == 2) drive_bit(u, stp[1]);
  endtask

  task automatic set_ready(input int u, input logic v);
    @(posedge clk);
    #1;
    rdy[u] = v;
    @(negedge clk);
  endtask

  task automatic wait_drain(input int u, input string name);
    for (int k = 0; k < 400; k++) begin
      if (qsize(u) == 0) break;
      @(negedge clk);
    end
    repeat (2) @(negedge clk);
    chk(name, 32'(qsize(u)), 32'd0);
  endtask

  initial begin
    rst  = 1'b1;
    rx_v = 3'b111;
    rdy  = 3'b111;

    vecs[0]  = '{0, 8'hA5, 1'b0, 2'b11, 1'b0, 1'b0};
    vecs[1]  = '{0, 8'h00, 1'b0, 2'b11, 1'b0, 1'b0};
    vecs[2]  = '{0, 8'hFF, 1'b0, 2'b11, 1'b0, 1'b0};
    vecs[3]  = '{0, 8'h3C, 1'b0, 2'b00, 1'b0, 1'b1};
    vecs[4]  = '{1, 8'h37, 1'b1, 2'b11, 1'b0, 1'b0};
    vecs[5]  = '{1, 8'h37, 1'b0, 2'b11, 1'b1, 1'b0};
    vecs[6]  = '{1, 8'h00, 1'b0, 2'b11, 1'b0, 1'b0};
    vecs[7]  = '{1, 8'h81, 1'b1, 2'b11, 1'b1, 1'b0};
    vecs[8]  = '{2, 8'h5A, 1'b0, 2'b01, 1'b0, 1'b1};
    vecs[9]  = '{2, 8'h5A, 1'b0, 2'b11, 1'b0, 1'b0};
    vecs[10] = '{2, 8'hC3, 1'b0, 2'b10, 1'b0, 1'b1};

    repeat (3) @(negedge clk);
    chk("rst_valid", 32'(mv), 32'd0);
    chk("rst_count0", 32'(cnt0), 32'd0);
    chk("rst_count12", 32'({cnt1, cnt2}), 32'd0);
    chk("rst_overrun", 32'(ovr), 32'd0);
    chk("rst_data0", 32'(md[0]), 32'd0);
    chk("rst_flags", 32'({pe, fe}), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    fork
      forever begin
        @(negedge clk);
        for (int u = 0; u < 3; u++) begin
          if (mv[u] && rdy[u]) begin
            mon_have = 1'b0;
            case (u)
              0: if (exp_q0.size() != 0) begin mon_e = exp_q0.pop_front(); mon_have = 1'b1; end
              1: if (exp_q1.size() != 0) begin mon_e = exp_q1.pop_front(); mon_have = 1'b1; end
              default: if (exp_q2.size() != 0) begin mon_e = exp_q2.pop_front(); mon_have = 1'b1; end
            endcase
            if (!mon_have) begin
              checks++;
              failures++;
              $display("FAIL unexpected_word unit=%0d got=0x%0h expected=none", u,
                       {pe[u], fe[u], md[u]});
            end else begin
              chk($sformatf("word_u%0d", u), 32'({pe[u], fe[u], md[u]}), 32'(mon_e));
            end
          end
        end
      end
    join_none

    // First frame also measures rx-edge to m_valid latency.
    push_exp(0, {2'b00, 8'hA5});
    fork
      send_frame(0, 8'hA5, 1'b0, 2'b11);
      begin
        lat = 0;
        while (!mv[0] && lat < 400) begin
          @(posedge clk);
          #1;
          lat++;
        end
      end
    join
    checks++;
    if (lat < 16 * 9 || lat > LAT_MAX) begin
      failures++;
      $display("FAIL latency got=%0d cycles required=144..%0d", lat, LAT_MAX);
    end
    idle_bits(0, 2);
    wait_drain(0, "lat_drain");
    chk("lat_single_beat", 32'(cnt0), 32'd0);

    for (int i = 0; i < 11; i++) begin
      push_exp(vecs[i].u, {vecs[i].eperr, vecs[i].eferr, vecs[i].d});
      send_frame(vecs[i].u, vecs[i].d, vecs[i].par, vecs[i].stp);
      idle_bits(vecs[i].u, 2);
      wait_drain(vecs[i].u, $sformatf("vec%0d_drain", i));
    end

    // Five back-to-back frames into a stalled depth-4 FIFO.
    set_ready(0, 1'b0);
    for (int i = 1; i <= 4; i++) push_exp(0, {2'b00, 8'(i)});
    ovr_cnt = 0;
    sending = 1'b1;
    fork
      begin
        for (int i = 1; i <= 5; i++) send_frame(0, 8'(i), 1'b0, 2'b11);
        idle_bits(0, 2);
        sending = 1'b0;
      end
      begin
        while (sending) begin
          @(negedge clk);
          if (ovr[0]) ovr_cnt++;
        end
      end
    join
    chk("ovr_fifo_count", 32'(cnt0), 32'd4);
    chk("ovr_pulses", 32'(ovr_cnt), 32'd1);
    set_ready(0, 1'b1);
    wait_drain(0, "ovr_drain");
    chk("ovr_empty", 32'(cnt0), 32'd0);

    // Short low pulse while idle must not produce a word.
    set_ready(0, 1'b0);
    rx_v[0] = 1'b0;
    repeat (4) @(negedge clk);
    rx_v[0] = 1'b1;
    repeat (60) @(negedge clk);
    chk("glitch_count", 32'(cnt0), 32'd0);
    chk("glitch_valid", 32'(mv[0]), 32'd0);

    // Reset in the middle of a frame flushes a stored word and the partial one.
    send_frame(0, 8'h11, 1'b0, 2'b11);
    idle_bits(0, 1);
    chk("pre_rst_count", 32'(cnt0), 32'd1);
    drive_bit(0, 1'b0);
    drive_bit(0, 1'b1);
    drive_bit(0, 1'b1);
    drive_bit(0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_valid", 32'(mv[0]), 32'd0);
    chk("rst_mid_count", 32'(cnt0), 32'd0);
    rst = 1'b0;
    rx_v[0] = 1'b1;
    idle_bits(0, 3);
    set_ready(0, 1'b1);
    push_exp(0, {2'b00, 8'hC3});
    send_frame(0, 8'hC3, 1'b0, 2'b11);
    idle_bits(0, 2);
    wait_drain(0, "c3_drain");

    // Break on the two-stop-bit unit: exactly one zero word with a framing error.
    set_ready(2, 1'b0);
    push_exp(2, {1'b0, 1'b1, 8'h00});
    rx_v[2] = 1'b0;
    repeat (20 * BIT_CLKS) @(negedge clk);
    chk("break_words_low", 32'(cnt2), 32'd1);
    rx_v[2] = 1'b1;
    idle_bits(2, 3);
    chk("break_words", 32'(cnt2), 32'd1);
    set_ready(2, 1'b1);
    wait_drain(2, "break_drain");
    push_exp(2, {2'b00, 8'h96});
    send_frame(2, 8'h96, 1'b0, 2'b11);
    idle_bits(2, 2);
    wait_drain(2, "post_break_drain");
    chk("final_counts", 32'({cnt0, cnt1, cnt2}), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Parametrised UART receiver, the successor to the fixed 8N1 receiver. It adds configurable data bits, optional parity, 1 or 2 stop bits, and 16x-oversampled majority-vote sampling behind a 2-flop input synchroniser. Received words, with per-word error flags, go into an internal FIFO read over a valid/ready stream interface. It sits between the pad-level rx line and SoC peripheral logic.

Parameters:
CLK_FREQ, 100_000_000, system clock frequency in Hz
BAUD_RATE, 115200, line baud rate
OVERSAMPLE, 16, sample ticks per bit; even, >= 8
DATA_BITS, 8, data bits per frame; legal range 5..9
PARITY_EN, 0, 1 = a parity bit follows the data bits
PARITY_ODD, 0, 1 = odd parity, 0 = even parity (used only when PARITY_EN = 1)
STOP_BITS, 1, number of stop bits, 1 or 2
FIFO_DEPTH, 8, FIFO entries; power of 2, >= 2

Ports:
clk  in  1  system clock, the only clock
rst  in  1  synchronous, active-high reset
rx  in  1  asynchronous serial input; idles high
m_data  out  DATA_BITS  FIFO head data word
m_parity_err  out  1  parity error flag of the head word
m_frame_err  out  1  framing error flag of the head word
m_valid  out  1  FIFO non-empty
m_ready  in  1  consumer accepts the head word when m_valid & m_ready
overrun  out  1  one-cycle pulse when a completed word is dropped because the FIFO is full
fifo_count  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- One clock (clk). Reset (rst) is synchronous and active-high.
- Reset values: synchroniser flops = 1; state = IDLE; tick divider = 0; FIFO empty; m_valid = 0; fifo_count = 0; overrun = 0; m_data, m_parity_err and m_frame_err = 0.
- Reset mid-frame aborts the frame, discards any partial word and flushes the FIFO.
- Input path: rx_s = rx delayed by two flops. All logic uses rx_s only.
- Tick generator: DIV = CLK_FREQ/(BAUD_RATE*OVERSAMPLE), minimum 1.
  - Free-running counter; `tick` is a one-cycle pulse every DIV clocks.
  - The counter restarts at 0 on the IDLE->START transition, so sampling is phase-aligned to the start edge.
- Sample counter sc (0..OVERSAMPLE-1) advances on each tick.
  - Bit value = majority of rx_s at sc = OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1.
  - The bit decision is taken at sc = OVERSAMPLE/2+1.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: on rx_s == 0, go to START with sc = 0.
  - START: if the start-bit vote is 1, treat it as a glitch and return to IDLE; no push, no flags. If the vote is 0, go to DATA at the end of the bit period (sc = OVERSAMPLE-1).
  - DATA: shift in DATA_BITS bits, LSB first. After the last bit, go to PARITY if PARITY_EN, else STOP.
  - PARITY: perr = (XOR of data bits ^ parity bit) != PARITY_ODD. With PARITY_EN = 0, perr = 0.
  - STOP: ferr = 1 if any stop-bit vote is 0. After the decision on the final stop bit, push {data, perr, ferr} and go to IDLE immediately, without waiting for the end of the bit. This allows back-to-back frames with no idle time.
- Break (all zeros, stop bit = 0): the word is pushed with ferr = 1. The FSM then re-enters IDLE and waits for rx_s to return high before it can detect the next start edge.
- FIFO:
  - Show-ahead: m_data, m_parity_err and m_frame_err present the head entry whenever m_valid = 1.
  - Pop occurs on m_valid & m_ready.
  - m_valid and fifo_count update on the cycle after a push or pop; push-to-m_valid latency is 1 clock.
  - A push and a pop in the same cycle leave fifo_count unchanged.
  - A push when full with a simultaneous pop is accepted.
  - A push when full with no pop drops the new word and pulses overrun for 1 cycle; FIFO contents are unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- Outputs are stable while m_valid & !m_ready.

Test Plan:
- Sim parameters for all scenarios: CLK_FREQ=1_600_000, BAUD_RATE=100_000, OVERSAMPLE=16, so one bit = 16 clocks.
- 8N1, send 0xA5, m_ready=1 -> a single m_valid beat with m_data=0xA5 and both error flags 0. m_valid rises 1 clock after the push, within 16*9+10 clocks of the start edge.
- PARITY_EN=1, PARITY_ODD=0: send 0x37 with correct parity bit 1, then 0x37 with parity bit 0 -> the first word has m_parity_err=0; the second has m_parity_err=1 and m_data=0x37.
- STOP_BITS=2: send 0x5A with the second stop bit driven 0 -> m_frame_err=1 and m_data=0x5A. Then send a break (rx low for 20 bits) -> one word 0x00 with m_frame_err=1, and no further words until rx returns high.
- m_ready=0, FIFO_DEPTH=4: send 5 back-to-back frames 0x01..0x05 -> fifo_count=4 and exactly one overrun pulse. Raising m_ready then pops 0x01, 0x02, 0x03, 0x04 in order.
- Glitches and reset: a 4-clock low pulse on rx while idle produces no word and no flags. Asserting rst mid-frame after 3 data bits gives m_valid=0 and fifo_count=0 on the next clock. A following clean 0xC3 frame is received correctly.
